// File: rtl/gato_control_turnos.sv
// Gato turn engine: validates move requests against board occupancy,
// records cell owners and rotates the turn, with optional idle auto-pass.
module gato_control_turnos #(
   parameter int NUM_JUGADORES  = 2,
   parameter int NUM_CASILLAS   = 9,
   parameter int TIMEOUT_CICLOS = 0,
   localparam int JW = $clog2(NUM_JUGADORES),
   localparam int CW = $clog2(NUM_CASILLAS),
   localparam int TW = $clog2(NUM_CASILLAS + 1)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       nueva_partida,
   input  logic                       jugada_valid,
   input  logic [CW-1:0]              jugada_casilla,
   output logic                       jugada_ready,
   output logic [JW-1:0]              jugador_actual,
   output logic                       jugada_ack,
   output logic                       jugada_rechazo,
   output logic                       turno_agotado,
   output logic [NUM_CASILLAS-1:0]    ocupado,
   output logic [NUM_CASILLAS*JW-1:0] dueno,
   output logic [TW-1:0]              num_jugadas,
   output logic                       tablero_lleno
);

   localparam int TOW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam int TO_LIM = (TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0;
   localparam logic [TOW-1:0] TO_MAX = TOW'(TO_LIM);
   localparam logic [JW-1:0] J_LAST = JW'(NUM_JUGADORES - 1);
   localparam logic [TW-1:0] N_FULL = TW'(NUM_CASILLAS);

   typedef enum logic [1:0] {ESPERA, EVALUA, FIN} estado_t;

   estado_t                    estado_q, estado_d;
   logic [CW-1:0]              cas_q, cas_d;
   logic [JW-1:0]              jug_q, jug_d;
   logic [NUM_CASILLAS-1:0]    ocup_q, ocup_d;
   logic [NUM_CASILLAS*JW-1:0] dueno_q, dueno_d;
   logic [TW-1:0]              num_q, num_d;
   logic [TOW-1:0]             cnt_q, cnt_d;
   logic                       ack_q, ack_d;
   logic                       rech_q, rech_d;
   logic                       agot_q, agot_d;
   logic                       lleno_q, lleno_d;
   logic                       transfer;
   logic                       libre;
   logic [JW-1:0]              jug_sig;

   assign jugada_ready = (estado_q == ESPERA) && !nueva_partida;
   assign transfer     = jugada_valid && jugada_ready;
   assign jug_sig      = (jug_q == J_LAST) ? '0 : jug_q + 1'b1;

   // Out-of-range cells never match any index, so they read as not free.
   always_comb begin
      libre = 1'b0;
      for (int i = 0; i < NUM_CASILLAS; i++) begin
         if (cas_q == CW'(i) && !ocup_q[i]) libre = 1'b1;
      end
   end

   always_comb begin
      estado_d = estado_q;
      cas_d    = cas_q;
      jug_d    = jug_q;
      ocup_d   = ocup_q;
      dueno_d  = dueno_q;
      num_d    = num_q;
      cnt_d    = cnt_q;
      lleno_d  = lleno_q;
      ack_d    = 1'b0;
      rech_d   = 1'b0;
      agot_d   = 1'b0;
      if (nueva_partida) begin
         estado_d = ESPERA;
         cas_d    = '0;
         jug_d    = '0;
         ocup_d   = '0;
         dueno_d  = '0;
         num_d    = '0;
         cnt_d    = '0;
         lleno_d  = 1'b0;
      end else begin
         case (estado_q)
            ESPERA: begin
               if (transfer) begin
                  cas_d    = jugada_casilla;
                  cnt_d    = '0;
                  estado_d = EVALUA;
               end else if (TIMEOUT_CICLOS > 0) begin
                  if (cnt_q == TO_MAX) begin
                     agot_d = 1'b1;
                     jug_d  = jug_sig;
                     cnt_d  = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            EVALUA: begin
               cnt_d    = '0;
               estado_d = ESPERA;
               if (libre) begin
                  ack_d = 1'b1;
                  for (int i = 0; i < NUM_CASILLAS; i++) begin
                     if (cas_q == CW'(i)) begin
                        ocup_d[i]             = 1'b1;
                        dueno_d[i*JW +: JW]   = jug_q;
                     end
                  end
                  num_d = num_q + 1'b1;
                  jug_d = jug_sig;
                  if ((num_q + 1'b1) == N_FULL) begin
                     estado_d = FIN;
                     lleno_d  = 1'b1;
                  end
               end else begin
                  rech_d = 1'b1;
               end
            end
            FIN: ;
            default: estado_d = ESPERA;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= ESPERA;
         cas_q    <= '0;
         jug_q    <= '0;
         ocup_q   <= '0;
         dueno_q  <= '0;
         num_q    <= '0;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         rech_q   <= 1'b0;
         agot_q   <= 1'b0;
         lleno_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cas_q    <= cas_d;
         jug_q    <= jug_d;
         ocup_q   <= ocup_d;
         dueno_q  <= dueno_d;
         num_q    <= num_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         rech_q   <= rech_d;
         agot_q   <= agot_d;
         lleno_q  <= lleno_d;
      end
   end

   assign jugador_actual = jug_q;
   assign jugada_ack     = ack_q;
   assign jugada_rechazo = rech_q;
   assign turno_agotado  = agot_q;
   assign ocupado        = ocup_q;
   assign dueno          = dueno_q;
   assign num_jugadas    = num_q;
   assign tablero_lleno  = lleno_q;

endmodule
